// File: rtl/dff_capture_arbiter.sv
// Round-robin arbiter that grants one requester at a time and captures the
// winner's data word into a single shared register, then holds off re-arbitration.
module dff_capture_arbiter #(
  parameter int N_REQ       = 4,
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   din,
  output logic [N_REQ-1:0]         gnt,
  output logic [WIDTH-1:0]         q,
  output logic                     q_valid,
  output logic [$clog2(N_REQ)-1:0] q_src,
  output logic                     busy,
  output logic [7:0]               cap_count
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N_REQ - 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [IW-1:0]     ptr_r, ptr_s;
  logic [IW-1:0]     win_r, win_s;
  logic [CW-1:0]     hold_cnt_r, hold_cnt_s;
  logic [N_REQ-1:0]  gnt_r, gnt_s;
  logic [WIDTH-1:0]  q_r, q_s;
  logic              q_valid_r, q_valid_s;
  logic [IW-1:0]     q_src_r, q_src_s;
  logic              busy_r, busy_s;
  logic [7:0]        cap_count_r, cap_count_s;

  logic              found_s;
  logic [IW-1:0]     winner_s;
  logic [IW:0]       cand_s;
  logic [WIDTH-1:0]  sel_s;

  // Round-robin search: first asserted request at or above ptr, wrapping.
  always_comb begin
    found_s  = 1'b0;
    winner_s = {IW{1'b0}};
    cand_s   = {(IW+1){1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      cand_s = {1'b0, ptr_r} + (IW+1)'(i);
      if (cand_s >= (IW+1)'(N_REQ)) begin
        cand_s = cand_s - (IW+1)'(N_REQ);
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && req[cand_s[IW-1:0]]) begin
        found_s  = 1'b1;
        winner_s = cand_s[IW-1:0];
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Only the granted requester's slice can reach the capture register.
  always_comb begin
    sel_s = {WIDTH{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      if (win_r == IW'(i)) begin
        sel_s = din[i*WIDTH +: WIDTH];
      end else begin
        sel_s = sel_s;
      end
    end
  end

  // Next-state and next-output computation for the IDLE/GRANT/HOLD sequence.
  always_comb begin
    state_s     = state_r;
    ptr_s       = ptr_r;
    win_s       = win_r;
    hold_cnt_s  = hold_cnt_r;
    gnt_s       = {N_REQ{1'b0}};
    q_s         = q_r;
    q_valid_s   = 1'b0;
    q_src_s     = q_src_r;
    cap_count_s = cap_count_r;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_s = GRANT;
          win_s   = winner_s;
          gnt_s   = {{(N_REQ-1){1'b0}}, 1'b1} << winner_s;
          if (winner_s == LAST_IDX) begin
            ptr_s = {IW{1'b0}};
          end else begin
            ptr_s = winner_s + IW'(1'b1);
          end
        end else begin
          state_s = IDLE;
        end
      end
      GRANT: begin
        state_s    = HOLD;
        hold_cnt_s = HOLD_LOAD;
        // A winner that dropped its request aborts without touching q.
        if (req[win_r]) begin
          q_s         = sel_s;
          q_valid_s   = 1'b1;
          q_src_s     = win_r;
          cap_count_s = cap_count_r + 8'd1;
        end else begin
          q_valid_s   = 1'b0;
        end
      end
      HOLD: begin
        if (hold_cnt_r == {CW{1'b0}}) begin
          state_s = IDLE;
        end else begin
          hold_cnt_s = hold_cnt_r - CW'(1'b1);
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State and output registers; reset overrides any in-flight capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      ptr_r       <= {IW{1'b0}};
      win_r       <= {IW{1'b0}};
      hold_cnt_r  <= {CW{1'b0}};
      gnt_r       <= {N_REQ{1'b0}};
      q_r         <= {WIDTH{1'b0}};
      q_valid_r   <= 1'b0;
      q_src_r     <= {IW{1'b0}};
      busy_r      <= 1'b0;
      cap_count_r <= 8'd0;
    end else begin
      state_r     <= state_s;
      ptr_r       <= ptr_s;
      win_r       <= win_s;
      hold_cnt_r  <= hold_cnt_s;
      gnt_r       <= gnt_s;
      q_r         <= q_s;
      q_valid_r   <= q_valid_s;
      q_src_r     <= q_src_s;
      busy_r      <= busy_s;
      cap_count_r <= cap_count_s;
    end
  end

  assign gnt       = gnt_r;
  assign q         = q_r;
  assign q_valid   = q_valid_r;
  assign q_src     = q_src_r;
  assign busy      = busy_r;
  assign cap_count = cap_count_r;

endmodule
